// File: rtl/fpcvt_pipe_if.sv
// Streaming interface for the pipelined int-to-float converter.
// Status flags exist only when FPCVT_STATUS_EN is defined.
interface fpcvt_pipe_if #(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned SIG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_s;
  logic [EXP_W-1:0] out_e;
  logic [SIG_W-1:0] out_f;
`ifdef FPCVT_STATUS_EN
  logic             out_sat;
  logic             out_inexact;
`endif

  // Source/sink side of the converter
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_s, out_e, out_f
`ifdef FPCVT_STATUS_EN
    , input out_sat, out_inexact
`endif
  );

  // Converter side
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_s, out_e, out_f
`ifdef FPCVT_STATUS_EN
    , output out_sat, out_inexact
`endif
  );
endinterface

// File: rtl/fpcvt_pipe.sv
// Three-stage pipelined two's-complement to (S, E, F) converter, value = F * 2^E.
// Optional FPCVT_STATUS_EN adds pipelined out_sat / out_inexact flags.
module fpcvt_pipe #(
  parameter int unsigned IN_W  = 13,
  parameter int unsigned EXP_W = 3,
  parameter int unsigned SIG_W = 5
) (
  input  logic         clk,
  input  logic         rst,
  fpcvt_pipe_if.slave  bus
);
  localparam int unsigned MW    = IN_W - 1;
  localparam int unsigned PW    = $clog2(MW);
  localparam int unsigned E_MAX = (1 << EXP_W) - 1;

  logic             v1, v2, v3;
  logic             adv1, adv2, adv3;
  logic             s1, s2, s3;
  logic [MW-1:0]    m1;
  logic [EXP_W-1:0] e2, e3;
  logic [SIG_W-1:0] f2, f3;
  logic             r2;

  logic             min_neg;
  logic [MW-1:0]    m_c;
  logic [PW-1:0]    p;
  logic [PW-1:0]    sh;
  int               e_full;
  logic [EXP_W-1:0] e2_c, e3_c;
  logic [SIG_W-1:0] f2_c, f3_c;
  logic             r2_c;
  logic [SIG_W:0]   sum;

  // Backpressure chain: a stage moves when empty or when its successor moves
  assign adv3 = !v3 || bus.out_ready;
  assign adv2 = !v2 || adv3;
  assign adv1 = !v1 || adv2;
  assign bus.in_ready = adv1;

  // Stage 1: sign-magnitude; the most-negative code clamps to the largest magnitude
  always_comb begin
    min_neg = bus.in_data[IN_W-1] && !(|bus.in_data[IN_W-2:0]);
    m_c     = MW'(bus.in_data[IN_W-1] ? (~bus.in_data + IN_W'(1)) : bus.in_data);
    if (min_neg) m_c = '1;
  end

  // Stage 2: locate the leading one and cut the significand window below it
  always_comb begin
    p = '0;
    for (int i = 0; i < int'(MW); i++)
      if (m1[i]) p = PW'(i);
    sh     = '0;
    e_full = 0;
    f2_c   = m1[SIG_W-1:0];
    r2_c   = 1'b0;
    if (int'(p) >= int'(SIG_W)) begin
      sh     = p - PW'(SIG_W - 1);
      e_full = int'(sh);
      f2_c   = SIG_W'(m1 >> sh);
      r2_c   = m1[p - PW'(SIG_W)];
    end
    e2_c = EXP_W'(e_full);
    if (e_full > int'(E_MAX)) begin
      e2_c = EXP_W'(E_MAX);
      f2_c = '1;
      r2_c = 1'b0;
    end
  end

  // Stage 3: round half up; the carry out of F+1 bumps the exponent or saturates
  always_comb begin
    sum  = {1'b0, f2} + (SIG_W+1)'(r2);
    e3_c = e2;
    f3_c = sum[SIG_W-1:0];
    if (sum[SIG_W]) begin
      if (e2 == EXP_W'(E_MAX)) begin
        f3_c = '1;
      end else begin
        f3_c = SIG_W'(1) << (SIG_W - 1);
        e3_c = e2 + EXP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0;
      m1 <= '0;
      e2 <= '0; f2 <= '0; r2 <= 1'b0;
      e3 <= '0; f3 <= '0;
    end else begin
      if (adv1) begin
        v1 <= bus.in_valid;
        if (bus.in_valid) begin
          s1 <= bus.in_data[IN_W-1];
          m1 <= m_c;
        end
      end
      if (adv2) begin
        v2 <= v1;
        if (v1) begin
          s2 <= s1; e2 <= e2_c; f2 <= f2_c; r2 <= r2_c;
        end
      end
      if (adv3) begin
        v3 <= v2;
        if (v2) begin
          s3 <= s2; e3 <= e3_c; f3 <= f3_c;
        end
      end
    end
  end

  assign bus.out_valid = v3;
  assign bus.out_s     = s3;
  assign bus.out_e     = e3;
  assign bus.out_f     = f3;

`ifdef FPCVT_STATUS_EN
  logic sat1, sat2, sat3, inx2, inx3;
  logic sat2_c, inx2_c, sat3_c;

  // Flags ride alongside the data with the same advance enables
  always_comb begin
    sat2_c = sat1 || (e_full > int'(E_MAX));
    inx2_c = |(m1 & ~({MW{1'b1}} << sh));
    sat3_c = sat2 || (sum[SIG_W] && (e2 == EXP_W'(E_MAX)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sat1 <= 1'b0; sat2 <= 1'b0; sat3 <= 1'b0;
      inx2 <= 1'b0; inx3 <= 1'b0;
    end else begin
      if (adv1 && bus.in_valid) sat1 <= min_neg;
      if (adv2 && v1) begin
        sat2 <= sat2_c;
        inx2 <= inx2_c;
      end
      if (adv3 && v2) begin
        sat3 <= sat3_c;
        inx3 <= inx2;
      end
    end
  end

  assign bus.out_sat     = sat3;
  assign bus.out_inexact = inx3;
`endif
endmodule

// File: tb/tb_fpcvt_pipe.sv
// Self-checking bench for fpcvt_pipe: directed spec values, random streaming
// against an arithmetic reference, backpressure and mid-stream reset.
module tb_fpcvt_pipe;
  localparam int IN_W  = 13;
  localparam int EXP_W = 3;
  localparam int SIG_W = 5;
  localparam int EMAX  = (1 << EXP_W) - 1;

  typedef struct packed {
    logic             s;
    logic [EXP_W-1:0] e;
    logic [SIG_W-1:0] f;
    logic             sat;
    logic             inx;
  } res_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  res_t exp_q[$];
  res_t obs_q[$];

  fpcvt_pipe_if #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) bif ();

  fpcvt_pipe #(.IN_W(IN_W), .EXP_W(EXP_W), .SIG_W(SIG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the magnitude
  function automatic res_t ref_cvt(input logic [IN_W-1:0] x);
    res_t o;
    int v, m, p, sh, fq, rem, e, mmax;
    bit r;
    o    = '0;
    mmax = (1 << (IN_W - 1)) - 1;
    v    = int'($signed(x));
    o.s  = x[IN_W-1];
    m    = (v < 0) ? -v : v;
    if (m > mmax) begin m = mmax; o.sat = 1'b1; end
    p = -1;
    for (int t = m; t > 0; t = t / 2) p++;
    e = 0; fq = m; r = 1'b0;
    if (p >= SIG_W) begin
      sh    = p - SIG_W + 1;
      e     = sh;
      fq    = m / (1 << sh);
      rem   = m % (1 << sh);
      r     = (rem >= (1 << (sh - 1)));
      o.inx = (rem != 0);
    end
    if (e > EMAX) begin e = EMAX; fq = (1 << SIG_W) - 1; r = 1'b0; o.sat = 1'b1; end
    fq = fq + int'(r);
    if (fq == (1 << SIG_W)) begin
      if (e == EMAX) begin fq = fq - 1; o.sat = 1'b1; end
      else begin fq = fq / 2; e = e + 1; end
    end
    o.e = EXP_W'(e);
    o.f = SIG_W'(fq);
`ifndef FPCVT_STATUS_EN
    o.sat = 1'b0;
    o.inx = 1'b0;
`endif
    return o;
  endfunction

  function automatic res_t cur_out();
    res_t o;
    o.s = bif.out_s;
    o.e = bif.out_e;
    o.f = bif.out_f;
`ifdef FPCVT_STATUS_EN
    o.sat = bif.out_sat;
    o.inx = bif.out_inexact;
`else
    o.sat = 1'b0;
    o.inx = 1'b0;
`endif
    return o;
  endfunction

  // Record every accepted input (as expected result) and every delivered output
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bif.in_valid && bif.in_ready) exp_q.push_back(ref_cvt(bif.in_data));
      if (bif.out_valid && bif.out_ready) obs_q.push_back(cur_out());
    end
  end

  task automatic idle();
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b want 0", bif.out_valid); end
    n_checks++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset in_ready got %b want 1", bif.in_ready); end
    n_checks++; if (cur_out() !== res_t'(0)) begin n_fail++; $display("FAIL reset outputs got %h want 0", cur_out()); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [IN_W-1:0]  din  [6];
    logic             ws   [6];
    logic [EXP_W-1:0] we   [6];
    logic [SIG_W-1:0] wf   [6];
    logic             wsat [6];
    logic             winx [6];
    int lat;
    din  = '{13'd0, 13'd422, 13'd127, 13'd125, 13'h1000, 13'h1FFF};
    ws   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    we   = '{3'd0, 3'd4, 3'd3, 3'd2, 3'd7, 3'd0};
    wf   = '{5'b00000, 5'b11010, 5'b10000, 5'b11111, 5'b11111, 5'b00001};
    wsat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    winx = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 6; k++) begin
      idle();
      bif.in_valid = 1'b1;
      bif.in_data  = din[k];
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        #1;
        bif.in_valid = 1'b0;
      end while (!bif.out_valid && lat < 10);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL latency[%h] got %0d want 3", din[k], lat); end
      n_checks++; if (bif.out_s !== ws[k]) begin n_fail++; $display("FAIL sign[%h] got %b want %b", din[k], bif.out_s, ws[k]); end
      n_checks++; if (bif.out_e !== we[k]) begin n_fail++; $display("FAIL exp[%h] got %0d want %0d", din[k], bif.out_e, we[k]); end
      n_checks++; if (bif.out_f !== wf[k]) begin n_fail++; $display("FAIL sig[%h] got %b want %b", din[k], bif.out_f, wf[k]); end
`ifdef FPCVT_STATUS_EN
      n_checks++; if (bif.out_sat !== wsat[k]) begin n_fail++; $display("FAIL sat[%h] got %b want %b", din[k], bif.out_sat, wsat[k]); end
      n_checks++; if (bif.out_inexact !== winx[k]) begin n_fail++; $display("FAIL inexact[%h] got %b want %b", din[k], bif.out_inexact, winx[k]); end
`endif
    end
  endtask

  task automatic test_random();
    logic [IN_W-1:0] edges [8];
    edges = '{13'h0000, 13'h0001, 13'h1FFF, 13'h1000, 13'h0FFF, 13'h007F, 13'h003F, 13'h0020};
    idle();
    for (int c = 0; c < 400; c++) begin
      bif.in_valid  = ($urandom_range(3) != 0);
      bif.out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(3) == 0) bif.in_data = edges[$urandom_range(7)];
      else                        bif.in_data = IN_W'($urandom);
      @(posedge clk);
      #1;
    end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random count got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [IN_W-1:0] base;
    int acc;
    bit have;
    res_t held;
    idle();
    base = IN_W'($urandom);
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    bif.in_data   = base;
    acc  = 0;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bif.in_ready) acc++;
      if (bif.out_valid) begin
        if (!have) begin held = cur_out(); have = 1'b1; end
        else begin
          n_checks++;
          if (cur_out() !== held) begin n_fail++; $display("FAIL hold[%0d] got %h want %h", i, cur_out(), held); end
        end
      end
      @(posedge clk);
      #1;
      bif.in_data = base + IN_W'(acc);
    end
    n_checks++; if (acc !== 3) begin n_fail++; $display("FAIL bp accepted got %0d want 3", acc); end
    n_checks++; if (bif.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp in_ready got %b want 0", bif.in_ready); end
    n_checks++; if (have !== 1'b1) begin n_fail++; $display("FAIL bp out_valid got %b want 1", have); end
    n_checks++; if (held !== ref_cvt(base)) begin n_fail++; $display("FAIL bp head got %h want %h", held, ref_cvt(base)); end
    bif.in_valid  = 1'b0;
    bif.out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() !== 3) begin n_fail++; $display("FAIL bp drained got %0d want 3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== ref_cvt(base + IN_W'(i))) begin n_fail++; $display("FAIL bp order[%0d] got %h want %h", i, obs_q[i], ref_cvt(base + IN_W'(i))); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [IN_W-1:0] post;
    idle();
    bif.out_ready = 1'b0;
    bif.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.in_data = IN_W'($urandom);
      @(posedge clk);
      #1;
    end
    bif.in_valid = 1'b0;
    n_checks++; if (bif.out_valid !== 1'b1) begin n_fail++; $display("FAIL pre-reset out_valid got %b want 1", bif.out_valid); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (bif.out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset out_valid got %b want 0", bif.out_valid); end
    n_checks++; if (bif.in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset in_ready got %b want 1", bif.in_ready); end
    bif.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() !== 0) begin n_fail++; $display("FAIL stale outputs got %0d want 0", obs_q.size()); end
    post = IN_W'($urandom);
    bif.in_valid = 1'b1;
    bif.in_data  = post;
    @(posedge clk);
    #1;
    bif.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (obs_q.size() !== 1) begin n_fail++; $display("FAIL post-reset count got %0d want 1", obs_q.size()); end
    if (obs_q.size() > 0) begin
      n_checks++;
      if (obs_q[0] !== ref_cvt(post)) begin n_fail++; $display("FAIL post-reset value got %h want %h", obs_q[0], ref_cvt(post)); end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
